// File: rtl/scan_bcd_multi.sv
`default_nettype none
// ============================================================================
//  Module   : scan_bcd_multi
//  Purpose  : Memory-mapped seven-segment scan driver. A chip-selected write
//             latches a binary word. The word is then either converted
//             serially to BCD (shift-add-3) or split into hex nibbles. The
//             driver blanks leading zeros, flags overflow with dashes, and
//             time-multiplexes up to eight active-low digits.
//  Ports    : scan_clk   - clock, all registers update on its rising edge
//             scan_rst   - synchronous active-high reset
//             scanwdata  - value to display (DATA_W bits)
//             scan_write - write strobe
//             scan_cs    - chip select; accept = scan_cs && scan_write
//             scan_mode  - 0 = unsigned decimal, 1 = hex (sampled on accept)
//             scan_busy  - conversion in progress or write pending
//             DIG        - active-low one-hot digit enables (registered)
//             Y          - active-low segments {dp,g..a}, dp off (registered)
//  Revision : 1.0  initial release
// ============================================================================
module scan_bcd_multi #(
    parameter int DIGITS      = 8,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 200000
) (
    input  logic              scan_clk,
    input  logic              scan_rst,
    input  logic [DATA_W-1:0] scanwdata,
    input  logic              scan_write,
    input  logic              scan_cs,
    input  logic              scan_mode,
    output logic              scan_busy,
    output logic [7:0]        DIG,
    output logic [7:0]        Y
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(DATA_W);
    localparam int c_PRE_W = $clog2(REFRESH_DIV);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'(DIGITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;

    // ------------------------------------------------------------------
    // Bus side: pending write register
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_start;
    logic              w_step;
    logic              w_commit;
    logic              r_pend_valid;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_pend_mode;

    assign w_accept = scan_cs && scan_write;

    // A new accept on the same edge that the FSM consumes the pending word
    // must keep the flag set, so the accept takes priority over the clear.
    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_mode  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= scanwdata;
                r_pend_mode  <= scan_mode;
            end else if (w_start) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_pend_valid) begin
                    w_state_next = r_pend_mode ? c_ST_LOAD : c_ST_CONV;
                end
            end
            c_ST_CONV: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_start  = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            c_ST_IDLE: w_start  = r_pend_valid;
            c_ST_CONV: w_step   = 1'b1;
            c_ST_LOAD: w_commit = 1'b1;
            default: ;
        endcase
    end

    assign scan_busy = (r_state != c_ST_IDLE) || r_pend_valid;

    // ------------------------------------------------------------------
    // Hex split of the pending word, with overflow for bits that do not fit
    // ------------------------------------------------------------------
    logic [c_BCD_W-1:0] w_hex_nib;
    logic               w_hex_ovf;

    generate
        if (DATA_W >= c_BCD_W) begin : g_hex_wide
            assign w_hex_nib = r_pend_data[c_BCD_W-1:0];
            if (DATA_W > c_BCD_W) begin : g_hex_ovf
                assign w_hex_ovf = |r_pend_data[DATA_W-1:c_BCD_W];
            end else begin : g_hex_fit
                assign w_hex_ovf = 1'b0;
            end
        end else begin : g_hex_narrow
            assign w_hex_nib = {{(c_BCD_W - DATA_W){1'b0}}, r_pend_data};
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shift-add-3 datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_shift;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic               r_ovf;
    logic               r_mode;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The hex path reuses the accumulator so LOAD copies one place either way.
    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_shift <= r_pend_data;
            r_mode  <= r_pend_mode;
            r_cnt   <= '0;
            if (r_pend_mode) begin
                r_bcd <= w_hex_nib;
                r_ovf <= w_hex_ovf;
            end else begin
                r_bcd <= '0;
                r_ovf <= 1'b0;
            end
        end else if (w_step) begin
            {r_bcd, r_shift} <= {w_bcd_adj[c_BCD_W-2:0], r_shift, 1'b0};
            // A one leaving the top nibble means the value needs more digits.
            if (w_bcd_adj[c_BCD_W-1]) begin
                r_ovf <= 1'b1;
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display register
    // ------------------------------------------------------------------
    logic [c_BCD_W-1:0] r_disp_nib;
    logic               r_disp_ovf;
    logic               r_disp_mode;

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_disp_nib  <= '0;
            r_disp_ovf  <= 1'b0;
            r_disp_mode <= 1'b0;
        end else if (w_commit) begin
            r_disp_nib  <= r_bcd;
            r_disp_ovf  <= r_ovf;
            r_disp_mode <= r_mode;
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic               w_pre_wrap;

    assign w_pre_wrap = (r_presc == c_PRE_LAST);

    always_comb begin
        w_idx_next = r_idx;
        if (w_pre_wrap) begin
            w_idx_next = (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else begin
            r_presc <= w_pre_wrap ? '0 : r_presc + 1'b1;
            r_idx   <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Rendering: nibble per digit padded to eight, leading-zero mask
    // ------------------------------------------------------------------
    logic [7:0][3:0] w_nib;
    logic [7:0]      w_lit;
    logic [3:0]      w_cur_nib;
    logic            w_cur_lit;
    logic [6:0]      w_seg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            if (gi < DIGITS) begin : g_used
                assign w_nib[gi] = r_disp_nib[4*gi +: 4];
            end else begin : g_unused
                assign w_nib[gi] = 4'd0;
            end
        end
    endgenerate

    // A digit is lit when it or any more-significant digit is nonzero;
    // digit 0 is always lit so that zero reads "0".
    always_comb begin : p_lit
        logic w_seen;
        w_seen = 1'b0;
        w_lit  = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            w_seen   = w_seen || (w_nib[i] != 4'd0);
            w_lit[i] = w_seen;
        end
        w_lit[0] = 1'b1;
    end

    // Outputs are built from the index the register is about to take, so
    // DIG and Y change on the same edge as the index.
    assign w_cur_nib = w_nib[w_idx_next];
    assign w_cur_lit = w_lit[w_idx_next];

    always_comb begin
        w_seg = 7'b0000000;
        if (r_disp_ovf) begin
            w_seg = 7'b1000000;
        end else if (w_cur_lit && (r_disp_mode || (w_cur_nib <= 4'd9))) begin
            case (w_cur_nib)
                4'h0: w_seg = 7'b0111111;
                4'h1: w_seg = 7'b0000110;
                4'h2: w_seg = 7'b1011011;
                4'h3: w_seg = 7'b1001111;
                4'h4: w_seg = 7'b1100110;
                4'h5: w_seg = 7'b1101101;
                4'h6: w_seg = 7'b1111101;
                4'h7: w_seg = 7'b0000111;
                4'h8: w_seg = 7'b1111111;
                4'h9: w_seg = 7'b1101111;
                4'hA: w_seg = 7'b1110111;
                4'hB: w_seg = 7'b1111100;
                4'hC: w_seg = 7'b0111001;
                4'hD: w_seg = 7'b1011110;
                4'hE: w_seg = 7'b1111001;
                default: w_seg = 7'b1110001;
            endcase
        end
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            DIG <= 8'hFE;
            Y   <= 8'hC0;
        end else begin
            DIG <= ~(8'd1 << w_idx_next);
            Y   <= {1'b1, ~w_seg};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_bcd_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_bcd_multi
//  Purpose  : Self-checking bench for scan_bcd_multi. Three instances with
//             DIGITS = 8, 4 and 3 share one stimulus stream; every cycle their
//             DIG, Y and scan_busy are compared with a transaction-level model
//             that renders the displayed value arithmetically.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_bcd_multi;

    localparam int DW = 16;
    localparam int R  = 4;

    logic          scan_clk   = 1'b0;
    logic          scan_rst   = 1'b1;
    logic [DW-1:0] scanwdata  = '0;
    logic          scan_write = 1'b0;
    logic          scan_cs    = 1'b0;
    logic          scan_mode  = 1'b0;

    logic       busy8, busy4, busy3;
    logic [7:0] dig8, dig4, dig3;
    logic [7:0] y8, y4, y3;

    always #5 scan_clk = ~scan_clk;

    scan_bcd_multi #(.DIGITS(8), .DATA_W(DW), .REFRESH_DIV(R)) u_d8 (
        .scan_clk(scan_clk), .scan_rst(scan_rst), .scanwdata(scanwdata),
        .scan_write(scan_write), .scan_cs(scan_cs), .scan_mode(scan_mode),
        .scan_busy(busy8), .DIG(dig8), .Y(y8));

    scan_bcd_multi #(.DIGITS(4), .DATA_W(DW), .REFRESH_DIV(R)) u_d4 (
        .scan_clk(scan_clk), .scan_rst(scan_rst), .scanwdata(scanwdata),
        .scan_write(scan_write), .scan_cs(scan_cs), .scan_mode(scan_mode),
        .scan_busy(busy4), .DIG(dig4), .Y(y4));

    scan_bcd_multi #(.DIGITS(3), .DATA_W(DW), .REFRESH_DIV(R)) u_d3 (
        .scan_clk(scan_clk), .scan_rst(scan_rst), .scanwdata(scanwdata),
        .scan_write(scan_write), .scan_cs(scan_cs), .scan_mode(scan_mode),
        .scan_busy(busy3), .DIG(dig3), .Y(y3));

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: k counts edges since the last reset edge.
    int            k        = 0;
    int            free_e   = 0;
    int            vis_e    = -1;
    logic          pend_m   = 1'b0;
    logic [DW-1:0] pend_v   = '0;
    logic          pend_md  = 1'b0;
    logic [DW-1:0] fly_v    = '0;
    logic          fly_md   = 1'b0;
    logic [DW-1:0] disp_v   = '0;
    logic          disp_md  = 1'b0;
    logic          busy_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'b0111111;
            1:  return 7'b0000110;
            2:  return 7'b1011011;
            3:  return 7'b1001111;
            4:  return 7'b1100110;
            5:  return 7'b1101101;
            6:  return 7'b1111101;
            7:  return 7'b0000111;
            8:  return 7'b1111111;
            9:  return 7'b1101111;
            10: return 7'b1110111;
            11: return 7'b1111100;
            12: return 7'b0111001;
            13: return 7'b1011110;
            14: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Expected Y for digit i of a d-digit display showing val in mode md.
    function automatic logic [7:0] exp_y(input int unsigned val, input logic md,
                                         input int d, input int i);
        longint     lim, base, radix;
        int         dg;
        logic [6:0] seg;
        radix = md ? 16 : 10;
        lim   = 1;
        base  = 1;
        for (int j = 0; j < d; j++) begin
            lim = lim * radix;
            if (j < i) base = base * radix;
        end
        dg = int'((longint'(val) / base) % radix);
        if (longint'(val) >= lim)                   seg = 7'b1000000;
        else if (i == 0 || longint'(val) >= base)   seg = glyph(dg);
        else                                        seg = 7'b0000000;
        return {1'b1, ~seg};
    endfunction

    task automatic chk_dut(input string nm, input int d, input logic [7:0] dg,
                           input logic [7:0] y, input logic b);
        int         idx;
        logic [7:0] dexp;
        idx  = (k / R) % d;
        dexp = ~(8'd1 << idx);
        check_eq({nm, ".DIG"},  32'(dg), 32'(dexp));
        check_eq({nm, ".Y"},    32'(y),  32'(exp_y(disp_v, disp_md, d, idx)));
        check_eq({nm, ".busy"}, 32'(b),  32'(busy_exp));
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare all three instances 1 time unit later.
    task automatic step();
        logic          acc, md, rst_s;
        logic [DW-1:0] d;
        acc   = scan_cs && scan_write;
        d     = scanwdata;
        md    = scan_mode;
        rst_s = scan_rst;
        @(posedge scan_clk);
        if (rst_s) begin
            k       = 0;
            free_e  = 0;
            vis_e   = -1;
            pend_m  = 1'b0;
            disp_v  = '0;
            disp_md = 1'b0;
        end else begin
            k++;
            if (k == vis_e) begin
                disp_v  = fly_v;
                disp_md = fly_md;
            end
            if (pend_m && k >= free_e) begin
                fly_v  = pend_v;
                fly_md = pend_md;
                free_e = k + (pend_md ? 2 : DW + 2);
                vis_e  = free_e;
                pend_m = 1'b0;
            end
            if (acc) begin
                pend_m  = 1'b1;
                pend_v  = d;
                pend_md = md;
            end
        end
        busy_exp = pend_m || (k <= free_e - 2);
        #1;
        if (!rst_s) begin
            chk_dut("d8", 8, dig8, y8, busy8);
            chk_dut("d4", 4, dig4, y4, busy4);
            chk_dut("d3", 3, dig3, y3, busy3);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [DW-1:0] v, input logic md);
        scanwdata  = v;
        scan_mode  = md;
        scan_cs    = 1'b1;
        scan_write = 1'b1;
        step();
        scan_cs    = 1'b0;
        scan_write = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] mask;

        // Reset held three cycles, then free-run scanning.
        scan_rst = 1'b1;
        run(3);
        scan_rst = 1'b0;
        run(40);

        // Decimal 305, overflow 12345 (on 3/4 digits), 9999, hex BEEF.
        wr(16'd305, 1'b0);    run(45);
        wr(16'd12345, 1'b0);  run(45);
        wr(16'd9999, 1'b0);   run(45);
        wr(16'hBEEF, 1'b1);   run(40);
        wr(16'd0, 1'b0);      run(40);

        // Back-to-back writes: 7 at N, 42 at N+1, 99 at N+5.
        wr(16'd7, 1'b0);
        wr(16'd42, 1'b0);
        run(3);
        wr(16'd99, 1'b0);
        run(70);

        // Reset during conversion cycle 5 of 500.
        wr(16'd500, 1'b0);
        run(5);
        scan_rst = 1'b1;
        step();
        scan_rst = 1'b0;
        run(60);

        // Randomised writes, modes, gaps and strobe/select combinations.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            scanwdata  = DW'($urandom) & mask;
            scan_mode  = 1'($urandom_range(0, 1));
            scan_cs    = ($urandom_range(0, 3) != 0);
            scan_write = ($urandom_range(0, 3) != 0);
            step();
            scan_cs    = 1'b0;
            scan_write = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                scan_rst = 1'b1;
                step();
                scan_rst = 1'b0;
            end
            run($urandom_range(0, 30));
        end
        run(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
